// File: rtl/sine_table_arbiter.sv
// -----------------------------------------------------------------------------
// sine_table_arbiter
//
// Arbitrates the single-port sine-table SPRAM between the waveform pipeline's
// per-cycle phase lookups and host sine-table writes. Host writes are queued in
// a small FIFO and committed on cycles where the pipeline issues no read. An
// age counter forces the head write through when reads never go idle.
//
// Ports:
//   i_Clock, i_Reset      clock, synchronous active-high reset
//   i_ReadRequest         pipeline lookup request this cycle
//   i_ReadAddress         lookup address
//   o_ReadValid           registered: o_ReadData holds last cycle's lookup
//   o_ReadDropped         registered: last cycle's request was preempted
//   o_ReadData            pass-through of i_RamDataOut
//   i_WriteValid          single-cycle host write strobe
//   i_WriteAddress/Data   host write address / data
//   o_WriteReady          FIFO not full
//   o_Pending             FIFO occupancy
//   o_Overflow            sticky: a strobe arrived while the FIFO was full
//   o_RamAddress/DataIn   SPRAM ADDRESS / DATAIN (combinational)
//   o_RamWriteEnable      SPRAM WREN (combinational)
//   o_RamMaskWrEn         SPRAM MASKWREN (all ones while writing)
//   i_RamDataOut          SPRAM DATAOUT
// -----------------------------------------------------------------------------
module sine_table_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 255
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_ReadRequest,
    input  logic [ADDR_WIDTH-1:0]         i_ReadAddress,
    output logic                          o_ReadValid,
    output logic                          o_ReadDropped,
    output logic [DATA_WIDTH-1:0]         o_ReadData,
    input  logic                          i_WriteValid,
    input  logic [ADDR_WIDTH-1:0]         i_WriteAddress,
    input  logic [DATA_WIDTH-1:0]         i_WriteData,
    output logic                          o_WriteReady,
    output logic [$clog2(FIFO_DEPTH):0]   o_Pending,
    output logic                          o_Overflow,
    output logic [ADDR_WIDTH-1:0]         o_RamAddress,
    output logic [DATA_WIDTH-1:0]         o_RamDataIn,
    output logic                          o_RamWriteEnable,
    output logic [3:0]                    o_RamMaskWrEn,
    input  logic [DATA_WIDTH-1:0]         i_RamDataOut
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    localparam logic [AGE_W-1:0] AGE_LIMIT  = AGE_W'(MAX_WAIT);
    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_READ,
        GRANT_WRITE,
        GRANT_FORCE
    } grant_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // Write buffer storage and state
    entry_t             fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AGE_W-1:0]   age_q, age_d;
    logic               read_valid_q, read_valid_d;
    logic               read_dropped_q, read_dropped_d;
    logic               overflow_q, overflow_d;

    logic [PTR_W-1:0]   occupancy;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    entry_t             head;
    entry_t             push_entry;
    grant_e             grant;

    // FIFO status. Pointers carry one extra wrap bit so that a full buffer
    // (difference == depth) is distinguishable from an empty one.
    always_comb begin
        occupancy  = wr_ptr_q - rd_ptr_q;
        fifo_empty = (occupancy == '0);
        fifo_full  = (occupancy == FULL_COUNT);
        head       = fifo_mem_q[rd_ptr_q[IDX_W-1:0]];
        push_entry = '{addr: i_WriteAddress, data: i_WriteData};
    end

    // Per-cycle grant. FORCE outranks the pipeline so a starving write always
    // lands within MAX_WAIT+1 cycles of reaching the head.
    always_comb begin
        grant = GRANT_IDLE;
        if (!fifo_empty && (age_q == AGE_LIMIT)) begin
            grant = GRANT_FORCE;
        end else if (i_ReadRequest) begin
            grant = GRANT_READ;
        end else if (!fifo_empty) begin
            grant = GRANT_WRITE;
        end
    end

    always_comb begin
        push = i_WriteValid && !fifo_full;
        pop  = (grant == GRANT_WRITE) || (grant == GRANT_FORCE);
    end

    // Next-state logic
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        age_d          = age_q;
        overflow_d     = overflow_q;
        read_valid_d   = (grant == GRANT_READ);
        read_dropped_d = (grant == GRANT_FORCE) && i_ReadRequest;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (i_WriteValid && fifo_full) begin
            overflow_d = 1'b1;
        end

        // Age tracks how long the current head has been waiting; it restarts
        // after every commit and stays at zero while nothing is queued.
        if (pop || fifo_empty) begin
            age_d = '0;
        end else if (age_q != AGE_LIMIT) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            age_q          <= '0;
            overflow_q     <= 1'b0;
            read_valid_q   <= 1'b0;
            read_dropped_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            age_q          <= age_d;
            overflow_q     <= overflow_d;
            read_valid_q   <= read_valid_d;
            read_dropped_q <= read_dropped_d;
        end
    end

    // NOTE: the buffer storage is deliberately not reset; entries are only
    // ever read between the pointers, which are reset, so stale contents are
    // unobservable and the array can map to plain registers or LUT RAM.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[IDX_W-1:0]] <= push_entry;
        end
    end

    // RAM-side drive. The SPRAM captures these at the same edge our state
    // advances, so a commit here pairs with the head pop at that edge.
    always_comb begin
        o_RamAddress     = i_ReadAddress;
        o_RamDataIn      = head.data;
        o_RamWriteEnable = 1'b0;
        o_RamMaskWrEn    = 4'b0000;
        if (pop) begin
            o_RamAddress     = head.addr;
            o_RamWriteEnable = 1'b1;
            o_RamMaskWrEn    = 4'b1111;
        end
    end

    always_comb begin
        o_ReadValid   = read_valid_q;
        o_ReadDropped = read_dropped_q;
        o_ReadData    = i_RamDataOut;
        o_WriteReady  = !fifo_full;
        o_Pending     = occupancy;
        o_Overflow    = overflow_q;
    end

endmodule

// File: tb/tb_sine_table_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sine_table_arbiter
//
// Directed bench for sine_table_arbiter (FIFO_DEPTH=4, MAX_WAIT=8) with a
// behavioural single-port RAM (registered read) attached to the RAM pins.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit
// later, well away from the edge.
// -----------------------------------------------------------------------------
module tb_sine_table_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rr;
    logic [AW-1:0] raddr;
    logic          rv;
    logic          rdrop;
    logic [DW-1:0] rdata;
    logic          wv;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wready;
    logic [2:0]    pending;
    logic          overflow;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [3:0]    ram_mask;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] ram_model [1 << AW];

    int checks = 0;
    int errors = 0;

    sine_table_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4),
        .MAX_WAIT   (8)
    ) dut (
        .i_Clock          (clk),
        .i_Reset          (rst),
        .i_ReadRequest    (rr),
        .i_ReadAddress    (raddr),
        .o_ReadValid      (rv),
        .o_ReadDropped    (rdrop),
        .o_ReadData       (rdata),
        .i_WriteValid     (wv),
        .i_WriteAddress   (waddr),
        .i_WriteData      (wdata),
        .o_WriteReady     (wready),
        .o_Pending        (pending),
        .o_Overflow       (overflow),
        .o_RamAddress     (ram_addr),
        .o_RamDataIn      (ram_din),
        .o_RamWriteEnable (ram_we),
        .o_RamMaskWrEn    (ram_mask),
        .i_RamDataOut     (ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port RAM: write when enabled, registered read of the same address.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_model[ram_addr] <= ram_din;
        end
        ram_dout <= ram_model[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        rr    = 1'b0;
        raddr = 14'h0123;
        wv    = 1'b0;
        waddr = '0;
        wdata = '0;
        tick();
        tick();
        settle();

        // Reset state
        check("rst_read_valid", rv, 0);
        check("rst_read_dropped", rdrop, 0);
        check("rst_overflow", overflow, 0);
        check("rst_pending", pending, 0);
        check("rst_write_ready", wready, 1);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_mask", ram_mask, 0);
        check("rst_ram_addr", ram_addr, 14'h0123);

        rst   = 1'b0;
        raddr = '0;
        tick();

        // Idle drain
        wv = 1'b1; waddr = 14'h0010; wdata = 16'hABCD;
        settle();
        check("drain_no_bypass", ram_we, 0);
        tick();
        wv = 1'b0;
        settle();
        check("drain_we", ram_we, 1);
        check("drain_addr", ram_addr, 14'h0010);
        check("drain_data", ram_din, 16'hABCD);
        check("drain_mask", ram_mask, 4'b1111);
        check("drain_pending_1", pending, 1);
        tick();
        settle();
        check("drain_pending_0", pending, 0);
        check("drain_we_off", ram_we, 0);

        // Preload address 5 through the host path
        wv = 1'b1; waddr = 14'h0005; wdata = 16'h1234;
        tick();
        wv = 1'b0;
        settle();
        check("preload_we", ram_we, 1);
        check("preload_addr", ram_addr, 14'h0005);
        tick();

        // Read priority
        rr = 1'b1; raddr = 14'h0005;
        wv = 1'b1; waddr = 14'h0020; wdata = 16'h5555;
        settle();
        check("rp_ram_addr", ram_addr, 14'h0005);
        check("rp_we_0", ram_we, 0);
        tick();
        wv = 1'b0;
        settle();
        check("rp_valid_1", rv, 1);
        check("rp_data_1", rdata, 16'h1234);
        check("rp_pending", pending, 1);
        check("rp_we_1", ram_we, 0);
        tick();
        settle();
        check("rp_valid_2", rv, 1);
        check("rp_data_2", rdata, 16'h1234);
        check("rp_we_2", ram_we, 0);
        tick();
        rr = 1'b0;
        settle();
        check("rp_commit_we", ram_we, 1);
        check("rp_commit_addr", ram_addr, 14'h0020);
        check("rp_commit_data", ram_din, 16'h5555);
        check("rp_valid_3", rv, 1);
        tick();
        settle();
        check("rp_valid_off", rv, 0);
        check("rp_pending_0", pending, 0);

        // Starvation: write enqueued at S0, forced on S9
        rr = 1'b1; raddr = 14'h0005;
        wv = 1'b1; waddr = 14'h0030; wdata = 16'h7777;
        tick();
        wv = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            settle();
            check($sformatf("starve_we_c%0d", k), ram_we, 0);
            check($sformatf("starve_drop_c%0d", k), rdrop, 0);
            tick();
        end
        settle();
        check("starve_force_we", ram_we, 1);
        check("starve_force_addr", ram_addr, 14'h0030);
        check("starve_force_data", ram_din, 16'h7777);
        check("starve_valid_before", rv, 1);
        tick();
        settle();
        check("starve_valid_dropped", rv, 0);
        check("starve_dropped", rdrop, 1);
        tick();
        settle();
        check("starve_valid_after", rv, 1);
        check("starve_dropped_after", rdrop, 0);
        check("starve_pending", pending, 0);

        // Full / overflow with reads held
        for (int i = 0; i < 5; i++) begin
            wv = 1'b1; waddr = AW'(14'h0040 + i); wdata = DW'(16'hA000 + i);
            if (i == 4) begin
                settle();
                check("full_ready_low", wready, 0);
                check("full_pending_4", pending, 4);
            end
            tick();
        end
        wv = 1'b0;
        settle();
        check("ovf_pending", pending, 4);
        check("ovf_ready", wready, 0);
        check("ovf_flag", overflow, 1);
        rr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("ovf_drain_we_%0d", i), ram_we, 1);
            check($sformatf("ovf_drain_addr_%0d", i), ram_addr, 32'h40 + i);
            check($sformatf("ovf_drain_data_%0d", i), ram_din, 32'hA000 + i);
            tick();
        end
        settle();
        check("ovf_fifth_lost", ram_we, 0);
        check("ovf_drained", pending, 0);
        check("ovf_sticky", overflow, 1);

        // Simultaneous push/pop at occupancy 2
        rr = 1'b1;
        wv = 1'b1; waddr = 14'h0050; wdata = 16'hC050;
        tick();
        waddr = 14'h0051; wdata = 16'hC051;
        tick();
        rr = 1'b0;
        waddr = 14'h0052; wdata = 16'hC052;
        settle();
        check("pp_pending_before", pending, 2);
        check("pp_commit0_addr", ram_addr, 14'h0050);
        check("pp_commit0_data", ram_din, 16'hC050);
        tick();
        wv = 1'b0;
        settle();
        check("pp_pending_same", pending, 2);
        check("pp_commit1_addr", ram_addr, 14'h0051);
        check("pp_commit1_data", ram_din, 16'hC051);
        tick();
        settle();
        check("pp_commit2_addr", ram_addr, 14'h0052);
        check("pp_commit2_data", ram_din, 16'hC052);
        tick();
        settle();
        check("pp_pending_end", pending, 0);
        check("pp_we_end", ram_we, 0);

        // Reset mid-operation
        rr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wv = 1'b1; waddr = AW'(14'h0060 + i); wdata = DW'(16'hD000 + i);
            tick();
        end
        wv = 1'b0;
        settle();
        check("mid_pending_3", pending, 3);
        check("mid_overflow_set", overflow, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr  = 1'b0;
        settle();
        check("mid_pending_0", pending, 0);
        check("mid_overflow_0", overflow, 0);
        check("mid_ready", wready, 1);
        check("mid_valid_0", rv, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid_no_write_%0d", i), ram_we, 0);
            tick();
            settle();
        end
        wv = 1'b1; waddr = 14'h0070; wdata = 16'hBEEF;
        settle();
        check("post_no_bypass", ram_we, 0);
        tick();
        wv = 1'b0;
        settle();
        check("post_we", ram_we, 1);
        check("post_addr", ram_addr, 14'h0070);
        check("post_data", ram_din, 16'hBEEF);
        tick();
        settle();
        check("post_pending", pending, 0);

        // Committed contents survive in the RAM
        check("ram_keep_0010", ram_model[14'h0010], 16'hABCD);
        check("ram_keep_0043", ram_model[14'h0043], 16'hA003);
        check("ram_keep_0070", ram_model[14'h0070], 16'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
